// File: rtl/lieat_vwb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lieat_vwb_ctrl
// Brief    : Vector writeback arbiter (VLSU/VALU round-robin onto the regfile
//            group write port) with a pending-write issue scoreboard.
// Revision : 1.0
// ============================================================================
module lieat_vwb_ctrl #(
    parameter int XLEN = 32,
    parameter int GRP  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    // VLSU writeback requester
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [4:0]                lsu_wb_rd,
    input  logic [GRP*XLEN/8-1:0]     lsu_wb_wmask,
    input  logic [GRP*XLEN-1:0]       lsu_wb_wdata,
    // VALU writeback requester
    input  logic                      alu_wb_valid,
    output logic                      alu_wb_ready,
    input  logic [4:0]                alu_wb_rd,
    input  logic [GRP*XLEN/8-1:0]     alu_wb_wmask,
    input  logic [GRP*XLEN-1:0]       alu_wb_wdata,
    // Register file group write port
    output logic                      vreg_wvalid,
    output logic [4:0]                vreg_rd0,
    output logic [GRP*XLEN/8-1:0]     vreg_wmask,
    output logic [GRP*XLEN-1:0]       vreg_wdata,
    // Issue hazard check
    input  logic                      iss_valid,
    input  logic [4:0]                iss_vd,
    input  logic [4:0]                iss_vs1,
    input  logic [4:0]                iss_vs2,
    input  logic                      iss_use_vs1,
    input  logic                      iss_use_vs2,
    input  logic                      iss_vm,
    input  logic                      iss_wr,
    output logic                      iss_stall,
    output logic [31:0]               pending,
    output logic                      wb_err
);

    localparam int REG_IDX   = 5;
    localparam int RGIDX_NUM = 32;
    localparam int WMASK_W   = GRP * XLEN / 8;
    localparam int WDATA_W   = GRP * XLEN;

    // Membership via modular 5-bit distance, so groups wrap past v31 to v0.
    function automatic logic [RGIDX_NUM-1:0] grp_mask(input logic [REG_IDX-1:0] base);
        logic [REG_IDX-1:0] diff;
        grp_mask = '0;
        for (int k = 0; k < RGIDX_NUM; k++) begin
            diff        = REG_IDX'(k) - base;
            grp_mask[k] = (diff < REG_IDX'(GRP));
        end
    endfunction

    logic                   rr_ptr_q, rr_ptr_d;
    logic                   wvalid_q, wvalid_d;
    logic [REG_IDX-1:0]     rd0_q, rd0_d;
    logic [WMASK_W-1:0]     wmask_q, wmask_d;
    logic [WDATA_W-1:0]     wdata_q, wdata_d;
    logic [RGIDX_NUM-1:0]   pending_q, pending_d;
    logic                   wb_err_q, wb_err_d;

    logic                   lsu_gnt, alu_gnt;
    logic [RGIDX_NUM-1:0]   hazard_mask, set_mask, clr_mask;
    logic                   stall;

    // ---------------- Arbitration ----------------
    always_comb begin
        lsu_gnt  = !reset && lsu_wb_valid && (!alu_wb_valid || !rr_ptr_q);
        alu_gnt  = !reset && alu_wb_valid && (!lsu_wb_valid ||  rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        if (lsu_gnt) begin
            rr_ptr_d = 1'b1;
        end else if (alu_gnt) begin
            rr_ptr_d = 1'b0;
        end
    end

    // ---------------- Output stage ----------------
    always_comb begin
        wvalid_d = lsu_gnt || alu_gnt;
        rd0_d    = rd0_q;
        wmask_d  = wmask_q;
        wdata_d  = wdata_q;
        if (lsu_gnt) begin
            rd0_d   = lsu_wb_rd;
            wmask_d = lsu_wb_wmask;
            wdata_d = lsu_wb_wdata;
        end else if (alu_gnt) begin
            rd0_d   = alu_wb_rd;
            wmask_d = alu_wb_wmask;
            wdata_d = alu_wb_wdata;
        end
    end

    // ---------------- Scoreboard ----------------
    always_comb begin
        hazard_mask = '0;
        if (iss_use_vs1) hazard_mask = hazard_mask | grp_mask(iss_vs1);
        if (iss_use_vs2) hazard_mask = hazard_mask | grp_mask(iss_vs2);
        if (!iss_vm)     hazard_mask = hazard_mask | RGIDX_NUM'(1);
        if (iss_wr)      hazard_mask = hazard_mask | grp_mask(iss_vd);
        stall    = iss_valid && (|(pending_q & hazard_mask));

        set_mask = (iss_valid && iss_wr && !stall) ? grp_mask(iss_vd) : '0;
        clr_mask = vreg_wvalid ? grp_mask(rd0_q) : '0;
        // Set applied after clear so a same-cycle set of a bit wins.
        pending_d = (pending_q & ~clr_mask) | set_mask;
        wb_err_d  = wb_err_q || (vreg_wvalid && (|(~pending_q & clr_mask)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            rd0_q     <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wvalid_q  <= wvalid_d;
            rd0_q     <= rd0_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign lsu_wb_ready = lsu_gnt;
    assign alu_wb_ready = alu_gnt;
    // An in-flight write is suppressed during the reset cycle itself.
    assign vreg_wvalid  = wvalid_q && !reset;
    assign vreg_rd0     = rd0_q;
    assign vreg_wmask   = wmask_q;
    assign vreg_wdata   = wdata_q;
    assign iss_stall    = stall;
    assign pending      = pending_q;
    assign wb_err       = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lieat_vwb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lieat_vwb_ctrl
// Brief    : Directed self-checking bench for lieat_vwb_ctrl.
// Revision : 1.0
// ============================================================================
module tb_lieat_vwb_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         lsu_wb_valid, lsu_wb_ready;
    logic [4:0]   lsu_wb_rd;
    logic [31:0]  lsu_wb_wmask;
    logic [255:0] lsu_wb_wdata;
    logic         alu_wb_valid, alu_wb_ready;
    logic [4:0]   alu_wb_rd;
    logic [31:0]  alu_wb_wmask;
    logic [255:0] alu_wb_wdata;
    logic         vreg_wvalid;
    logic [4:0]   vreg_rd0;
    logic [31:0]  vreg_wmask;
    logic [255:0] vreg_wdata;
    logic         iss_valid;
    logic [4:0]   iss_vd, iss_vs1, iss_vs2;
    logic         iss_use_vs1, iss_use_vs2, iss_vm, iss_wr;
    logic         iss_stall;
    logic [31:0]  pending;
    logic         wb_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [255:0] data_a, data_b;

    lieat_vwb_ctrl #(.XLEN(32), .GRP(8)) dut (
        .clock(clock), .reset(reset),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready), .lsu_wb_rd(lsu_wb_rd),
        .lsu_wb_wmask(lsu_wb_wmask), .lsu_wb_wdata(lsu_wb_wdata),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_rd(alu_wb_rd),
        .alu_wb_wmask(alu_wb_wmask), .alu_wb_wdata(alu_wb_wdata),
        .vreg_wvalid(vreg_wvalid), .vreg_rd0(vreg_rd0), .vreg_wmask(vreg_wmask),
        .vreg_wdata(vreg_wdata),
        .iss_valid(iss_valid), .iss_vd(iss_vd), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2),
        .iss_use_vs1(iss_use_vs1), .iss_use_vs2(iss_use_vs2), .iss_vm(iss_vm),
        .iss_wr(iss_wr), .iss_stall(iss_stall), .pending(pending), .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd16;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_cnt++;
            if (lsu_wb_ready !== 1'b0) $display("FAIL reset_lsu_ready: got %b expected 0", lsu_wb_ready);
            else pass_cnt++;
            chk_cnt++;
            if (alu_wb_ready !== 1'b0) $display("FAIL reset_alu_ready: got %b expected 0", alu_wb_ready);
            else pass_cnt++;
            tick();
        end
        reset = 1'b0;
        lsu_wb_valid = 1'b0;
        alu_wb_valid = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd0;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b expected 0", vreg_wvalid);
        else pass_cnt++;
        chk_cnt++;
        if (pending !== 32'h0) $display("FAIL reset_pending: got %h expected 00000000", pending);
        else pass_cnt++;
        chk_cnt++;
        if (wb_err !== 1'b0) $display("FAIL reset_wb_err: got %b expected 0", wb_err);
        else pass_cnt++;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", iss_stall);
        else pass_cnt++;
        chk_cnt++;
        if (vreg_rd0 !== 5'd0 || vreg_wdata !== 256'h0) $display("FAIL reset_payload: got rd %0d data %h expected 0", vreg_rd0, vreg_wdata);
        else pass_cnt++;
        iss_valid = 1'b0; iss_wr = 1'b0;
    endtask

    task automatic test_raw;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd8;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL raw_issue_stall: got %b expected 0", iss_stall);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        #1;
        chk_cnt++;
        if (pending !== 32'h0000FF00) $display("FAIL raw_pending_set: got %h expected 0000ff00", pending);
        else pass_cnt++;
        iss_valid = 1'b1; iss_use_vs1 = 1'b1; iss_vs1 = 5'd12;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd8; alu_wb_wmask = 32'hFFFFFFFF; alu_wb_wdata = data_b;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b1) $display("FAIL raw_stall_vs1: got %b expected 1", iss_stall);
        else pass_cnt++;
        chk_cnt++;
        if (alu_wb_ready !== 1'b1 || lsu_wb_ready !== 1'b0) $display("FAIL raw_alu_grant: got alu %b lsu %b expected 1 0", alu_wb_ready, lsu_wb_ready);
        else pass_cnt++;
        tick();
        alu_wb_valid = 1'b0;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b1 || vreg_rd0 !== 5'd8) $display("FAIL raw_wb_out: got wvalid %b rd %0d expected 1 8", vreg_wvalid, vreg_rd0);
        else pass_cnt++;
        chk_cnt++;
        if (iss_stall !== 1'b1) $display("FAIL raw_stall_n1: got %b expected 1", iss_stall);
        else pass_cnt++;
        tick();
        #1;
        chk_cnt++;
        if (pending !== 32'h0) $display("FAIL raw_pending_clr: got %h expected 00000000", pending);
        else pass_cnt++;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL raw_unstall: got %b expected 0", iss_stall);
        else pass_cnt++;
        iss_valid = 1'b0; iss_use_vs1 = 1'b0;
    endtask

    task automatic test_wrap;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd28;
        tick();
        iss_wr = 1'b0; iss_use_vs2 = 1'b1; iss_vs2 = 5'd2;
        #1;
        chk_cnt++;
        if (pending !== 32'hF000000F) $display("FAIL wrap_pending: got %h expected f000000f", pending);
        else pass_cnt++;
        chk_cnt++;
        if (iss_stall !== 1'b1) $display("FAIL wrap_vs2_2: got %b expected 1", iss_stall);
        else pass_cnt++;
        iss_vs2 = 5'd4;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL wrap_vs2_4: got %b expected 0", iss_stall);
        else pass_cnt++;
        iss_use_vs2 = 1'b0; iss_vm = 1'b0;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b1) $display("FAIL wrap_masked_v0: got %b expected 1", iss_stall);
        else pass_cnt++;
        iss_valid = 1'b0;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL wrap_no_valid: got %b expected 0", iss_stall);
        else pass_cnt++;
        iss_vm = 1'b1;
    endtask

    task automatic test_waw;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd0;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b1) $display("FAIL waw_stall: got %b expected 1", iss_stall);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        #1;
        chk_cnt++;
        if (pending !== 32'hF000000F) $display("FAIL waw_pending_kept: got %h expected f000000f", pending);
        else pass_cnt++;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd28;
        #1;
        chk_cnt++;
        if (alu_wb_ready !== 1'b1) $display("FAIL waw_alu_only_grant: got %b expected 1", alu_wb_ready);
        else pass_cnt++;
        tick();
        alu_wb_valid = 1'b0;
        tick();
        #1;
        chk_cnt++;
        if (pending !== 32'h0 || wb_err !== 1'b0) $display("FAIL waw_cleanup: got pending %h err %b expected 00000000 0", pending, wb_err);
        else pass_cnt++;
    endtask

    task automatic test_set_clear;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd0;
        tick();
        iss_vd = 5'd8;
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0;
        #1;
        chk_cnt++;
        if (pending !== 32'h0000FFFF) $display("FAIL sc_pending_pre: got %h expected 0000ffff", pending);
        else pass_cnt++;
        tick();
        lsu_wb_valid = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd16;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b1 || vreg_rd0 !== 5'd0 || iss_stall !== 1'b0)
            $display("FAIL sc_same_cycle: got wvalid %b rd %0d stall %b expected 1 0 0", vreg_wvalid, vreg_rd0, iss_stall);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        #1;
        chk_cnt++;
        if (pending !== 32'h00FFFF00) $display("FAIL sc_pending_post: got %h expected 00ffff00", pending);
        else pass_cnt++;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8;
        tick();
        lsu_wb_rd = 5'd16;
        #1;
        chk_cnt++;
        if (lsu_wb_ready !== 1'b1) $display("FAIL sc_b2b_grant: got %b expected 1", lsu_wb_ready);
        else pass_cnt++;
        tick();
        lsu_wb_valid = 1'b0;
        tick();
        chk_cnt++;
        if (pending !== 32'h0 || wb_err !== 1'b0) $display("FAIL sc_cleanup: got pending %h err %b expected 00000000 0", pending, wb_err);
        else pass_cnt++;
    endtask

    task automatic test_error;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd16;
        #1;
        chk_cnt++;
        if (alu_wb_ready !== 1'b1) $display("FAIL err_grant: got %b expected 1", alu_wb_ready);
        else pass_cnt++;
        tick();
        alu_wb_valid = 1'b0;
        #1;
        chk_cnt++;
        if (wb_err !== 1'b0) $display("FAIL err_not_yet: got %b expected 0", wb_err);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (wb_err !== 1'b1) $display("FAIL err_set: got %b expected 1", wb_err);
        else pass_cnt++;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd24;
        tick();
        lsu_wb_valid = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_vd = 5'd24;
        #1;
        chk_cnt++;
        if (iss_stall !== 1'b0) $display("FAIL err_setwin_stall: got %b expected 0", iss_stall);
        else pass_cnt++;
        tick();
        iss_valid = 1'b0; iss_wr = 1'b0;
        #1;
        chk_cnt++;
        if (pending !== 32'hFF000000) $display("FAIL err_set_wins: got %h expected ff000000", pending);
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (wb_err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", wb_err);
        else pass_cnt++;
    endtask

    task automatic test_arbitration;
        logic [4:0] exp_rd;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8;  lsu_wb_wmask = 32'h0000000F; lsu_wb_wdata = data_a;
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd16; alu_wb_wmask = 32'hFFFFFFFF; alu_wb_wdata = data_b;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++;
            if (lsu_wb_ready !== ((i % 2) == 0) || alu_wb_ready !== ((i % 2) == 1))
                $display("FAIL arb_grant_%0d: got lsu %b alu %b", i, lsu_wb_ready, alu_wb_ready);
            else pass_cnt++;
            if (i > 0) begin
                exp_rd = (((i - 1) % 2) == 0) ? 5'd8 : 5'd16;
                chk_cnt++;
                if (vreg_wvalid !== 1'b1 || vreg_rd0 !== exp_rd)
                    $display("FAIL arb_out_%0d: got wvalid %b rd %0d expected 1 %0d", i, vreg_wvalid, vreg_rd0, exp_rd);
                else pass_cnt++;
            end
            tick();
        end
        lsu_wb_valid = 1'b0; alu_wb_valid = 1'b0;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b1 || vreg_rd0 !== 5'd16 || vreg_wmask !== 32'hFFFFFFFF || vreg_wdata !== data_b)
            $display("FAIL arb_last_out: got wvalid %b rd %0d mask %h data %h", vreg_wvalid, vreg_rd0, vreg_wmask, vreg_wdata);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (vreg_wvalid !== 1'b0 || vreg_rd0 !== 5'd16 || vreg_wdata !== data_b)
            $display("FAIL arb_idle_hold: got wvalid %b rd %0d data %h expected 0 16 held", vreg_wvalid, vreg_rd0, vreg_wdata);
        else pass_cnt++;
        lsu_wb_valid = 1'b1;
        #1;
        chk_cnt++;
        if (lsu_wb_ready !== 1'b1) $display("FAIL arb_lsu_only: got %b expected 1", lsu_wb_ready);
        else pass_cnt++;
        tick();
        lsu_wb_valid = 1'b0;
        #1;
        chk_cnt++;
        if (vreg_rd0 !== 5'd8 || vreg_wmask !== 32'h0000000F || vreg_wdata !== data_a)
            $display("FAIL arb_lsu_payload: got rd %0d mask %h data %h", vreg_rd0, vreg_wmask, vreg_wdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_drop;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8;
        tick();
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b0 || lsu_wb_ready !== 1'b0)
            $display("FAIL drop_on_reset: got wvalid %b ready %b expected 0 0", vreg_wvalid, lsu_wb_ready);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        lsu_wb_valid = 1'b0;
        #1;
        chk_cnt++;
        if (vreg_wvalid !== 1'b0 || pending !== 32'h0 || wb_err !== 1'b0)
            $display("FAIL drop_after: got wvalid %b pending %h err %b", vreg_wvalid, pending, wb_err);
        else pass_cnt++;
    endtask

    initial begin
        data_a = {8{32'hA5A5_0001}};
        data_b = {8{32'h5A5A_F00D}};
        reset = 1'b1;
        lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_wmask = '0; lsu_wb_wdata = '0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_wmask = '0; alu_wb_wdata = '0;
        iss_valid = 1'b0; iss_vd = '0; iss_vs1 = '0; iss_vs2 = '0;
        iss_use_vs1 = 1'b0; iss_use_vs2 = 1'b0; iss_vm = 1'b1; iss_wr = 1'b0;

        test_reset();
        test_raw();
        test_wrap();
        test_waw();
        test_set_clear();
        test_error();
        test_reset();
        test_arbitration();
        test_reset_drop();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lieat_vwb_ctrl.md
# lieat_vwb_ctrl

Vector writeback controller sitting between the vector execution units and `lieat_vregfile`'s single 8-register group write port. It round-robin arbitrates writeback requests from the VLSU and the VALU onto that port through one registered output stage. It also keeps a 32-entry pending-write scoreboard that stalls issue of any vector instruction whose source, mask or destination group overlaps an outstanding write.

## Interface
Parameters:
- `XLEN`, 32: element/register width; `REG_IDX` fixed at 5 and `RGIDX_NUM` at 32, both from the global defines.
- `GRP`, 8: registers per group; fixed, not for override.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `lsu_wb_valid`  in  1  VLSU writeback request.
- `lsu_wb_ready`  out  1  VLSU request granted this cycle.
- `lsu_wb_rd`  in  5  base register of the group.
- `lsu_wb_wmask`  in  32  byte masks; bits [4k+3:4k] belong to group member k.
- `lsu_wb_wdata`  in  256  data; bits [32k+31:32k] belong to group member k.
- `alu_wb_valid`, `alu_wb_ready`, `alu_wb_rd`, `alu_wb_wmask`, `alu_wb_wdata`: the VALU requester, with the same widths and meanings.
- `vreg_wvalid`  out  1  registered write strobe to the regfile.
- `vreg_rd0`  out  5  registered group base.
- `vreg_wmask`  out  32  registered masks; the top level slices these into `vreg_wmask0..7`.
- `vreg_wdata`  out  256  registered data; the top level slices these into `vreg_wdata0..7`.
- `iss_valid`  in  1  decode presents an instruction this cycle.
- `iss_vd`  in  5  destination group base.
- `iss_vs1`  in  5  source 1 base.
- `iss_vs2`  in  5  source 2 base.
- `iss_use_vs1`  in  1  instruction reads vs1.
- `iss_use_vs2`  in  1  instruction reads vs2.
- `iss_vm`  in  1  0 means the instruction is masked and reads v0.
- `iss_wr`  in  1  instruction writes vd.
- `iss_stall`  out  1  hazard; the instruction must not issue.
- `pending`  out  32  scoreboard state, for debug/verification.
- `wb_err`  out  1  sticky error: a writeback arrived for a non-pending register.

## Operation
- **Group membership.** Register r belongs to the group with base b iff ((r − b) mod 32) < 8, computed by 5-bit subtraction. Groups wrap, so base 28 covers v28–v31 and v0–v3.
- **Arbitration.**
  - `rr_ptr` = 0 favours LSU; `rr_ptr` = 1 favours ALU.
  - If only one requester is valid, it is granted.
  - If both are valid, the favoured one is granted.
  - After any grant, `rr_ptr` points to the source that was not granted.
  - `*_wb_ready` is combinational and equals the grant; at most one is high.
  - Both readies are 0 while `reset` is high.
  - A requester holds valid and its payload stable until it sees ready.
- **Output stage.**
  - On a grant, the winner's rd, wmask and wdata are registered and `vreg_wvalid` is set to 1.
  - With no grant, `vreg_wvalid` goes to 0. `vreg_rd0`, `vreg_wmask` and `vreg_wdata` hold their last values; the regfile ignores them.
  - The port is never back-pressured, so one grant is possible every cycle.
- **Scoreboard.**
  - `iss_stall` = `iss_valid` & (any pending bit within one of the following groups):
    - group(vs1) when `iss_use_vs1`;
    - group(vs2) when `iss_use_vs2`;
    - v0 when `iss_vm` = 0;
    - group(vd) when `iss_wr` (WAW).
  - The stall is combinational from the registered `pending` only.
  - Set: when `iss_valid` & `iss_wr` & !`iss_stall`, all 8 bits of group(vd) are set at the edge.
  - Clear: when `vreg_wvalid` = 1, all 8 bits of group(`vreg_rd0`) are cleared at the same edge as the regfile write.
  - If a set and a clear hit the same bit in one cycle, set wins.
  - `wb_err` is set when `vreg_wvalid` = 1 and any bit of group(`vreg_rd0`) is 0. It clears only on reset.

## Timing
- Reset values:
  - `vreg_wvalid`, `vreg_rd0`, `vreg_wmask` and `vreg_wdata` are 0.
  - `pending` = 0, `rr_ptr` = 0, `wb_err` = 0.
  - `iss_stall` = 0, since no bits are pending.
- Reset asserted mid-operation drops any in-flight output-stage write. The regfile does not see a write on the reset cycle.
- Writeback sequence:
  - Grant in cycle N.
  - `vreg_wvalid` is high in cycle N+1; the regfile captures at the end of N+1.
  - Pending bits clear at the end of N+1.
  - A dependent instruction un-stalls in N+2 and reads the new data the same cycle.
- Issue sequence:
  - An issue accepted in cycle M shows its pending bits from M+1.
  - A writeback for it can be granted in M+1 at the earliest.
- Arbitration has no bubble: back-to-back grants run at 1 per cycle, alternating when both sources stay valid.

## Test plan
- **Reset:** hold `reset` for 2 cycles with both sources valid. Both readies stay 0, and `vreg_wvalid` = 0 and `pending` = 0 afterwards.
- **Arbitration:** both sources valid continuously with rd 8 (LSU) and rd 16 (ALU). Grants go LSU, ALU, LSU, ALU. `vreg_wvalid` = 1 every cycle from the second cycle on, and `vreg_rd0` follows 8, 16, 8, 16.
- **RAW hazard:**
  - Issue vd = 8 with `iss_wr` = 1; `pending` becomes 0x0000FF00.
  - Present vs1 = 12; `iss_stall` = 1.
  - ALU writeback with rd = 8 is granted in cycle N. `pending` = 0 after N+1, and `iss_stall` = 0 in N+2.
- **Wrap-around:**
  - Issue vd = 28; `pending` becomes 0xF000000F.
  - vs2 = 2 stalls, vs2 = 4 does not.
  - A masked instruction (`iss_vm` = 0) stalls while v0 is pending.
- **Errors:**
  - Writeback with rd = 16 while `pending` = 0 sets `wb_err` = 1, and it stays set until reset.
  - WAW: issue vd = 0 while v3 is pending gives `iss_stall` = 1 and leaves `pending` unchanged.
- **Simultaneous set and clear:**
  - Pending groups 0 and 8; `vreg_wvalid` = 1 with rd 0 in the same cycle as issue of vd = 16.
  - Result: `pending` = 0x00FFFF00 next cycle.
